wb_stream_fifo_slave: RTL and testbench
=======================================

# wb_stream_fifo_slave

Wishbone-classic slave that sits directly downstream of the TT04 pin-to-Wishbone master and is the first peripheral on its bus. It exposes control/status/scratch registers plus a TX word FIFO drained by a valid/ready stream toward the USB engine, and an RX word FIFO filled by a stream from it. The CPU pushes and pops 32-bit words one bus transaction at a time. Every access is acknowledged exactly once.

## Interface
- TX_DEPTH_LOG2, 2: TX FIFO depth is 2**TX_DEPTH_LOG2 words; legal range 1..7.
- RX_DEPTH_LOG2, 2: RX FIFO depth is 2**RX_DEPTH_LOG2 words; legal range 1..7.
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- wb_CYC, wb_STB, wb_WE  in  1  Wishbone classic master controls.
- wb_ADR  in  14  word address; 32-bit aligned only.
- wb_DAT_MOSI  in  32  write data.
- wb_SEL  in  4  byte enables.
- wb_ACK  out  1  single-cycle acknowledge.
- wb_DAT_MISO  out  32  read data; valid only while wb_ACK=1, 0 otherwise.
- tx_data  out  32  head of TX FIFO; 0 when tx_valid=0.
- tx_valid  out  1  TX word available.
- tx_ready  in  1  downstream accepts the word.
- rx_data  in  32  inbound word.
- rx_valid  in  1  inbound word present.
- rx_ready  out  1  RX FIFO accepts the word.

## Operation
- Address map (full 14-bit decode, word addresses):
  - 0x0 CTRL RW: [0] tx_en, [1] rx_en. [8] tx_flush and [9] rx_flush are write-1 self-clearing and read 0.
  - 0x1 STATUS RO: [7:0] tx_count, [15:8] rx_count, [16] tx_full, [17] tx_empty, [18] rx_full, [19] rx_empty, [24] tx_ovf, [25] rx_udf. Writing 1 to bit 24 or 25 clears that flag (W1C).
  - 0x2 TXDATA WO: a write pushes wb_DAT_MOSI. A read returns 0.
  - 0x3 RXDATA RO: a read pops the head word. A write is ignored.
  - 0x4 SCRATCH RW: 32-bit.
  - Any other address: reads return 0, writes are ignored, and the access is still ACKed.
- Writes take effect only when wb_SEL=4'hF. Other SEL values are ACKed with no side effect.
- Push to a full TX FIFO: the word is dropped and tx_ovf is set. The rejection uses the full flag at the start of that cycle, even if a stream pop happens in the same cycle.
- Pop from an empty RX FIFO: returns 0 and sets rx_udf.
- Stream side:
  - tx_valid = tx_en & !tx_empty. A TX pop occurs on tx_valid & tx_ready.
  - rx_ready = rx_en & !rx_full. An RX push occurs on rx_valid & rx_ready.
- Flush empties the FIFO (pointers and count to 0) and wins over a simultaneous stream pop or push. An RX word handshaken in the flush cycle is lost, by design.
- A simultaneous push and pop on a non-full, non-empty FIFO leaves the count unchanged.
- Pointers wrap modulo depth. Counts are DEPTH_LOG2+1 bits, zero-extended into their 8-bit STATUS fields.

## Timing
- Reset values: all registers, counts, sticky flags and pointers are 0, and both FIFOs are empty. wb_ACK=0, wb_DAT_MISO=0, tx_valid=0, tx_data=0, rx_ready=0.
- FIFO memory contents are not reset.
- ACK rule: ack_next = CYC & STB & !ACK, registered.
  - The master raises STB in cycle N. ACK is high for the single cycle N+1, with wb_DAT_MISO registered alongside it.
  - The master drops STB at the edge ending N+1.
  - There is no back-to-back ACK without STB first going low.
- Side effects (push, pop, CTRL/SCRATCH write, W1C, flush) commit at the same edge that sets ACK, once per transaction.
- Read data reflects state before that edge's side effects.
- Effect latency:
  - A TXDATA push is visible on tx_valid/tx_count at N+1.
  - An RX stream push is visible in STATUS read data one cycle later.
- Reset asserted mid-transaction: ACK forced 0 next edge, and no partial side effect occurs.

## Structure
- Shared package holds:
  - register addresses (REG_CTRL..REG_SCRATCH);
  - CTRL and STATUS bit positions;
  - WB_ADR_W=14 and WB_DAT_W=32.
- Sub-module wb_sync_fifo is parameterised on WIDTH and DEPTH_LOG2:
  - synchronous, first-word fall-through;
  - ports push, pop, flush, data in/out, full, empty, count;
  - instantiated twice, once for TX and once for RX.
- The top level holds the decode, the ACK generator, CTRL/SCRATCH/sticky registers and the stream gating.

## Test plan
- Reset, then one STB read of STATUS -> a single-cycle ACK one cycle after STB, with read data 0x000A_0000 (both FIFOs empty).
- Write 0xDEADBEEF to SCRATCH with SEL=F, then with SEL=3 write 0x0 -> a SCRATCH read returns 0xDEADBEEF.
- Push 5 words into TXDATA with tx_en=0 and depth 4 -> tx_count=4, tx_full=1, tx_ovf=1. Then W1C bit 24 -> tx_ovf=0.
- Set tx_en=1 with tx_ready=1 -> the 4 words emerge in order on consecutive cycles, then tx_valid=0 and tx_data=0.
- rx_en=1 with 2 stream words 0x11 and 0x22, then 3 RXDATA reads -> 0x11, 0x22, 0, and rx_udf=1.
- Fill RX, then write CTRL=0x202 while rx_valid=1 -> rx_count=0 next cycle, and CTRL reads 0x002.

Source files
------------

// File: rtl/wb_stream_fifo_slave_pkg.sv
// Shared register map, bit positions and bus widths for the Wishbone stream FIFO slave.
// Also provides the address-to-register decoder used by the top level.
package wb_stream_fifo_slave_pkg;

    localparam int WB_ADR_W = 14;
    localparam int WB_DAT_W = 32;

    localparam logic [WB_ADR_W-1:0] REG_CTRL    = 14'h0;
    localparam logic [WB_ADR_W-1:0] REG_STATUS  = 14'h1;
    localparam logic [WB_ADR_W-1:0] REG_TXDATA  = 14'h2;
    localparam logic [WB_ADR_W-1:0] REG_RXDATA  = 14'h3;
    localparam logic [WB_ADR_W-1:0] REG_SCRATCH = 14'h4;

    localparam int CTRL_TX_EN    = 0;
    localparam int CTRL_RX_EN    = 1;
    localparam int CTRL_TX_FLUSH = 8;
    localparam int CTRL_RX_FLUSH = 9;

    localparam int STAT_TX_COUNT = 0;
    localparam int STAT_RX_COUNT = 8;
    localparam int STAT_TX_FULL  = 16;
    localparam int STAT_TX_EMPTY = 17;
    localparam int STAT_RX_FULL  = 18;
    localparam int STAT_RX_EMPTY = 19;
    localparam int STAT_TX_OVF   = 24;
    localparam int STAT_RX_UDF   = 25;

    typedef enum logic [2:0] {
        SEL_CTRL,
        SEL_STATUS,
        SEL_TXDATA,
        SEL_RXDATA,
        SEL_SCRATCH,
        SEL_NONE
    } reg_sel_e;

    // Full 14-bit decode: aliases of the five registers fall into SEL_NONE.
    function automatic reg_sel_e decode_reg(input logic [WB_ADR_W-1:0] adr);
        case (adr)
            REG_CTRL:    return SEL_CTRL;
            REG_STATUS:  return SEL_STATUS;
            REG_TXDATA:  return SEL_TXDATA;
            REG_RXDATA:  return SEL_RXDATA;
            REG_SCRATCH: return SEL_SCRATCH;
            default:     return SEL_NONE;
        endcase
    endfunction

endpackage

// File: rtl/wb_stream_fifo_slave_if.sv
// Wishbone classic bus plus TX/RX valid-ready streams for the FIFO slave.
interface wb_stream_fifo_slave_if;
    import wb_stream_fifo_slave_pkg::*;

    logic                wb_CYC;
    logic                wb_STB;
    logic                wb_WE;
    logic [WB_ADR_W-1:0] wb_ADR;
    logic [WB_DAT_W-1:0] wb_DAT_MOSI;
    logic [3:0]          wb_SEL;
    logic                wb_ACK;
    logic [WB_DAT_W-1:0] wb_DAT_MISO;

    logic [WB_DAT_W-1:0] tx_data;
    logic                tx_valid;
    logic                tx_ready;
    logic [WB_DAT_W-1:0] rx_data;
    logic                rx_valid;
    logic                rx_ready;

    modport master (
        output wb_CYC, wb_STB, wb_WE, wb_ADR, wb_DAT_MOSI, wb_SEL,
        output tx_ready, rx_data, rx_valid,
        input  wb_ACK, wb_DAT_MISO, tx_data, tx_valid, rx_ready
    );

    modport slave (
        input  wb_CYC, wb_STB, wb_WE, wb_ADR, wb_DAT_MOSI, wb_SEL,
        input  tx_ready, rx_data, rx_valid,
        output wb_ACK, wb_DAT_MISO, tx_data, tx_valid, rx_ready
    );

endinterface

// File: rtl/wb_stream_fifo_slave_fifo.sv
// Synchronous first-word-fall-through FIFO; push is refused when full and pop when empty.
// Flush clears pointers and count and overrides any push/pop in the same cycle.
module wb_sync_fifo #(
    parameter int WIDTH      = 32,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic                  pop,
    input  logic                  flush,
    input  logic [WIDTH-1:0]      din,
    output logic [WIDTH-1:0]      dout,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic                  do_push;
    logic                  do_pop;

    assign full    = (count == (DEPTH_LOG2+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push && !flush && !reset) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_stream_fifo_slave.sv
// Wishbone classic slave with CTRL/STATUS/SCRATCH registers, a CPU-filled TX FIFO drained
// by a stream, and a stream-filled RX FIFO drained by CPU reads.
module wb_stream_fifo_slave
    import wb_stream_fifo_slave_pkg::*;
#(
    parameter int TX_DEPTH_LOG2 = 2,
    parameter int RX_DEPTH_LOG2 = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    wb_stream_fifo_slave_if.slave  bus
);

    logic                  ack_q;
    logic [WB_DAT_W-1:0]   miso_q;
    logic                  tx_en_q;
    logic                  rx_en_q;
    logic                  tx_ovf_q;
    logic                  rx_udf_q;
    logic [WB_DAT_W-1:0]   scratch_q;

    reg_sel_e              reg_sel;
    logic                  access;
    logic                  wr_ok;
    logic                  rd_acc;
    logic [WB_DAT_W-1:0]   rd_data;

    logic                  tx_push, tx_pop, tx_flush, tx_full, tx_empty, tx_valid_int;
    logic                  rx_push, rx_pop, rx_flush, rx_full, rx_empty, rx_ready_int;
    logic [WB_DAT_W-1:0]   tx_head;
    logic [WB_DAT_W-1:0]   rx_head;
    logic [TX_DEPTH_LOG2:0] tx_count;
    logic [RX_DEPTH_LOG2:0] rx_count;

    // One access per transaction: the cycle that raises ACK is the only commit cycle.
    assign access  = bus.wb_CYC & bus.wb_STB & ~ack_q;
    assign reg_sel = decode_reg(bus.wb_ADR);
    assign wr_ok   = access & bus.wb_WE & (bus.wb_SEL == 4'hF);
    assign rd_acc  = access & ~bus.wb_WE;

    assign tx_push  = wr_ok & (reg_sel == SEL_TXDATA);
    assign rx_pop   = rd_acc & (reg_sel == SEL_RXDATA);
    assign tx_flush = wr_ok & (reg_sel == SEL_CTRL) & bus.wb_DAT_MOSI[CTRL_TX_FLUSH];
    assign rx_flush = wr_ok & (reg_sel == SEL_CTRL) & bus.wb_DAT_MOSI[CTRL_RX_FLUSH];

    assign tx_valid_int = tx_en_q & ~tx_empty;
    assign rx_ready_int = rx_en_q & ~rx_full;
    assign tx_pop       = tx_valid_int & bus.tx_ready;
    assign rx_push      = rx_ready_int & bus.rx_valid;

    wb_sync_fifo #(.WIDTH(WB_DAT_W), .DEPTH_LOG2(TX_DEPTH_LOG2)) u_tx_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (tx_push),
        .pop   (tx_pop),
        .flush (tx_flush),
        .din   (bus.wb_DAT_MOSI),
        .dout  (tx_head),
        .full  (tx_full),
        .empty (tx_empty),
        .count (tx_count)
    );

    wb_sync_fifo #(.WIDTH(WB_DAT_W), .DEPTH_LOG2(RX_DEPTH_LOG2)) u_rx_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (rx_push),
        .pop   (rx_pop),
        .flush (rx_flush),
        .din   (bus.rx_data),
        .dout  (rx_head),
        .full  (rx_full),
        .empty (rx_empty),
        .count (rx_count)
    );

    always_comb begin
        rd_data = '0;
        case (reg_sel)
            SEL_CTRL: begin
                rd_data[CTRL_TX_EN] = tx_en_q;
                rd_data[CTRL_RX_EN] = rx_en_q;
            end
            SEL_STATUS: begin
                rd_data[STAT_TX_COUNT +: 8] = 8'(tx_count);
                rd_data[STAT_RX_COUNT +: 8] = 8'(rx_count);
                rd_data[STAT_TX_FULL]       = tx_full;
                rd_data[STAT_TX_EMPTY]      = tx_empty;
                rd_data[STAT_RX_FULL]       = rx_full;
                rd_data[STAT_RX_EMPTY]      = rx_empty;
                rd_data[STAT_TX_OVF]        = tx_ovf_q;
                rd_data[STAT_RX_UDF]        = rx_udf_q;
            end
            SEL_RXDATA:  rd_data = rx_empty ? '0 : rx_head;
            SEL_SCRATCH: rd_data = scratch_q;
            default:     rd_data = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ack_q     <= 1'b0;
            miso_q    <= '0;
            tx_en_q   <= 1'b0;
            rx_en_q   <= 1'b0;
            tx_ovf_q  <= 1'b0;
            rx_udf_q  <= 1'b0;
            scratch_q <= '0;
        end else begin
            ack_q  <= access;
            miso_q <= rd_acc ? rd_data : '0;
            if (wr_ok && reg_sel == SEL_CTRL) begin
                tx_en_q <= bus.wb_DAT_MOSI[CTRL_TX_EN];
                rx_en_q <= bus.wb_DAT_MOSI[CTRL_RX_EN];
            end
            if (wr_ok && reg_sel == SEL_SCRATCH) begin
                scratch_q <= bus.wb_DAT_MOSI;
            end
            // Overflow judged on the full flag before any same-cycle stream pop.
            if (tx_push && tx_full) begin
                tx_ovf_q <= 1'b1;
            end else if (wr_ok && reg_sel == SEL_STATUS && bus.wb_DAT_MOSI[STAT_TX_OVF]) begin
                tx_ovf_q <= 1'b0;
            end
            if (rx_pop && rx_empty) begin
                rx_udf_q <= 1'b1;
            end else if (wr_ok && reg_sel == SEL_STATUS && bus.wb_DAT_MOSI[STAT_RX_UDF]) begin
                rx_udf_q <= 1'b0;
            end
        end
    end

    assign bus.wb_ACK      = ack_q;
    assign bus.wb_DAT_MISO = miso_q;
    assign bus.tx_valid    = tx_valid_int;
    assign bus.tx_data     = tx_valid_int ? tx_head : '0;
    assign bus.rx_ready    = rx_ready_int;

endmodule

// File: tb/tb_wb_stream_fifo_slave.sv
// Directed bench for wb_stream_fifo_slave: queue-based reference model checked every cycle,
// plus literal expectations on register reads and stream output.
module tb_wb_stream_fifo_slave;

    localparam int DEPTH = 4;

    logic clk;
    logic reset;

    wb_stream_fifo_slave_if bus_if();

    wb_stream_fifo_slave #(.TX_DEPTH_LOG2(2), .RX_DEPTH_LOG2(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: FIFOs as queues, registers as plain variables.
    logic [31:0] tx_q[$];
    logic [31:0] rx_q[$];
    logic        m_live = 1'b0;
    logic        m_ack, m_tx_en, m_rx_en, m_ovf, m_udf;
    logic [31:0] m_miso, m_scratch;

    function automatic logic [31:0] m_status();
        logic [31:0] s;
        s = '0;
        s[7:0]   = 8'(tx_q.size());
        s[15:8]  = 8'(rx_q.size());
        s[16]    = (tx_q.size() == DEPTH);
        s[17]    = (tx_q.size() == 0);
        s[18]    = (rx_q.size() == DEPTH);
        s[19]    = (rx_q.size() == 0);
        s[24]    = m_ovf;
        s[25]    = m_udf;
        return s;
    endfunction

    initial begin
        logic        m_txv, m_rxr, acc, wr, tx_full0, rx_empty0;
        logic [31:0] m_txd, rd, dat;
        logic [13:0] adr;
        forever begin
            @(negedge clk);
            m_txv = m_tx_en && (tx_q.size() != 0);
            m_txd = m_txv ? tx_q[0] : 32'h0;
            m_rxr = m_rx_en && (rx_q.size() < DEPTH);
            if (m_live) begin
                chk("cyc_ack",      {31'b0, bus_if.wb_ACK},   {31'b0, m_ack});
                chk("cyc_miso",     bus_if.wb_DAT_MISO,       m_miso);
                chk("cyc_tx_valid", {31'b0, bus_if.tx_valid}, {31'b0, m_txv});
                chk("cyc_tx_data",  bus_if.tx_data,           m_txd);
                chk("cyc_rx_ready", {31'b0, bus_if.rx_ready}, {31'b0, m_rxr});
            end
            if (reset) begin
                tx_q.delete();
                rx_q.delete();
                m_ack = 0; m_miso = 0; m_tx_en = 0; m_rx_en = 0;
                m_ovf = 0; m_udf = 0; m_scratch = 0;
                m_live = 1'b1;
            end else if (m_live) begin
                acc = bus_if.wb_CYC && bus_if.wb_STB && !m_ack;
                adr = bus_if.wb_ADR;
                dat = bus_if.wb_DAT_MOSI;
                wr  = acc && bus_if.wb_WE && (bus_if.wb_SEL == 4'hF);
                rd  = 32'h0;
                case (adr)
                    14'h0: rd = {30'b0, m_rx_en, m_tx_en};
                    14'h1: rd = m_status();
                    14'h3: rd = (rx_q.size() != 0) ? rx_q[0] : 32'h0;
                    14'h4: rd = m_scratch;
                    default: rd = 32'h0;
                endcase
                tx_full0  = (tx_q.size() == DEPTH);
                rx_empty0 = (rx_q.size() == 0);
                if (m_txv && bus_if.tx_ready) void'(tx_q.pop_front());
                if (wr && adr == 14'h2) begin
                    if (tx_full0) m_ovf = 1'b1;
                    else tx_q.push_back(dat);
                end
                if (acc && !bus_if.wb_WE && adr == 14'h3) begin
                    if (rx_empty0) m_udf = 1'b1;
                    else void'(rx_q.pop_front());
                end
                if (m_rxr && bus_if.rx_valid) rx_q.push_back(bus_if.rx_data);
                if (wr && adr == 14'h0) begin
                    m_tx_en = dat[0];
                    m_rx_en = dat[1];
                    if (dat[8]) tx_q.delete();
                    if (dat[9]) rx_q.delete();
                end
                if (wr && adr == 14'h1) begin
                    if (dat[24]) m_ovf = 1'b0;
                    if (dat[25]) m_udf = 1'b0;
                end
                if (wr && adr == 14'h4) m_scratch = dat;
                m_miso = (acc && !bus_if.wb_WE) ? rd : 32'h0;
                m_ack  = acc;
            end
        end
    end

    // Called one time unit after a rising edge; returns at the same phase.
    task automatic wb_xfer(input logic we, input logic [13:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, output logic [31:0] rd);
        bus_if.wb_CYC      = 1'b1;
        bus_if.wb_STB      = 1'b1;
        bus_if.wb_WE       = we;
        bus_if.wb_ADR      = adr;
        bus_if.wb_DAT_MOSI = dat;
        bus_if.wb_SEL      = sel;
        @(posedge clk); #1;
        chk("wb_ack", {31'b0, bus_if.wb_ACK}, 32'h1);
        rd = bus_if.wb_DAT_MISO;
        bus_if.wb_CYC = 1'b0;
        bus_if.wb_STB = 1'b0;
        bus_if.wb_WE  = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic wb_write(input logic [13:0] adr, input logic [31:0] dat, input logic [3:0] sel);
        logic [31:0] unused_rd;
        wb_xfer(1'b1, adr, dat, sel, unused_rd);
    endtask

    task automatic wb_read_chk(input string name, input logic [13:0] adr, input logic [31:0] exp);
        logic [31:0] rd;
        wb_xfer(1'b0, adr, 32'h0, 4'hF, rd);
        chk(name, rd, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, n_fail=%0d", n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        reset              = 1'b1;
        bus_if.wb_CYC      = 1'b0;
        bus_if.wb_STB      = 1'b0;
        bus_if.wb_WE       = 1'b0;
        bus_if.wb_ADR      = '0;
        bus_if.wb_DAT_MOSI = '0;
        bus_if.wb_SEL      = 4'h0;
        bus_if.tx_ready    = 1'b0;
        bus_if.rx_data     = '0;
        bus_if.rx_valid    = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        chk("rst_ack",      {31'b0, bus_if.wb_ACK},   32'h0);
        chk("rst_miso",     bus_if.wb_DAT_MISO,       32'h0);
        chk("rst_tx_valid", {31'b0, bus_if.tx_valid}, 32'h0);
        chk("rst_rx_ready", {31'b0, bus_if.rx_ready}, 32'h0);
        @(posedge clk); #1;

        wb_read_chk("status_reset", 14'h1, 32'h000A_0000);

        wb_write(14'h4, 32'hDEAD_BEEF, 4'hF);
        wb_write(14'h4, 32'h0000_0000, 4'h3);
        wb_read_chk("scratch_sel", 14'h4, 32'hDEAD_BEEF);

        for (int i = 0; i < 5; i++) wb_write(14'h2, 32'hA0 + 32'(i), 4'hF);
        wb_read_chk("status_tx_ovf", 14'h1, 32'h0109_0004);
        wb_write(14'h1, 32'h0100_0000, 4'hF);
        wb_read_chk("status_ovf_clr", 14'h1, 32'h0009_0004);

        wb_write(14'h0, 32'h1, 4'hF);
        bus_if.tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("tx_stream_valid", {31'b0, bus_if.tx_valid}, 32'h1);
            chk("tx_stream_data",  bus_if.tx_data, 32'hA0 + 32'(i));
            @(posedge clk); #1;
        end
        chk("tx_drained_valid", {31'b0, bus_if.tx_valid}, 32'h0);
        chk("tx_drained_data",  bus_if.tx_data, 32'h0);

        wb_write(14'h0, 32'h3, 4'hF);
        bus_if.rx_valid = 1'b1;
        bus_if.rx_data  = 32'h11;
        @(posedge clk); #1;
        bus_if.rx_data  = 32'h22;
        @(posedge clk); #1;
        bus_if.rx_valid = 1'b0;
        wb_read_chk("rx_pop0", 14'h3, 32'h11);
        wb_read_chk("rx_pop1", 14'h3, 32'h22);
        wb_read_chk("rx_pop_empty", 14'h3, 32'h0);
        wb_read_chk("status_rx_udf", 14'h1, 32'h020A_0000);

        bus_if.rx_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus_if.rx_data = 32'h100 + 32'(i);
            @(posedge clk); #1;
        end
        chk("rx_full_ready", {31'b0, bus_if.rx_ready}, 32'h0);
        wb_read_chk("status_rx_full", 14'h1, 32'h0206_0400);

        // CTRL flush write issued while rx_valid is still asserted.
        bus_if.wb_CYC      = 1'b1;
        bus_if.wb_STB      = 1'b1;
        bus_if.wb_WE       = 1'b1;
        bus_if.wb_ADR      = 14'h0;
        bus_if.wb_DAT_MOSI = 32'h202;
        bus_if.wb_SEL      = 4'hF;
        @(posedge clk); #1;
        chk("flush_ack",      {31'b0, bus_if.wb_ACK},   32'h1);
        chk("flush_rx_ready", {31'b0, bus_if.rx_ready}, 32'h1);
        bus_if.rx_valid = 1'b0;
        bus_if.wb_CYC   = 1'b0;
        bus_if.wb_STB   = 1'b0;
        bus_if.wb_WE    = 1'b0;
        @(posedge clk); #1;
        wb_read_chk("status_flushed", 14'h1, 32'h020A_0000);
        wb_read_chk("ctrl_after_flush", 14'h0, 32'h0000_0002);

        wb_write(14'h1, 32'h0300_0000, 4'hF);
        wb_read_chk("status_udf_clr", 14'h1, 32'h000A_0000);
        wb_read_chk("txdata_read", 14'h2, 32'h0);
        wb_read_chk("unmapped_read", 14'h1234, 32'h0);
        wb_write(14'h0, 32'h1, 4'h7);
        wb_read_chk("ctrl_partial_sel", 14'h0, 32'h0000_0002);

        // Reset asserted in the same cycle as a SCRATCH write: no side effect, no ACK.
        bus_if.wb_CYC      = 1'b1;
        bus_if.wb_STB      = 1'b1;
        bus_if.wb_WE       = 1'b1;
        bus_if.wb_ADR      = 14'h4;
        bus_if.wb_DAT_MOSI = 32'h55;
        bus_if.wb_SEL      = 4'hF;
        reset              = 1'b1;
        @(posedge clk); #1;
        chk("midrst_ack", {31'b0, bus_if.wb_ACK}, 32'h0);
        reset         = 1'b0;
        bus_if.wb_CYC = 1'b0;
        bus_if.wb_STB = 1'b0;
        bus_if.wb_WE  = 1'b0;
        @(posedge clk); #1;
        wb_read_chk("midrst_scratch", 14'h4, 32'h0);
        wb_read_chk("midrst_ctrl", 14'h0, 32'h0);

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
